eespfal_phase_seq: RTL

- Digital sequencer that drives a BIT_SIZE-wide, STAGES-deep chain of EESPFAL dual-rail switch cells. It is the parametrised successor to the fixed 4-bit switch macro.
- Converts single-rail operands and per-stage keys to dual-rail, and generates the per-bit power-clock (CLK vector), Dis and Dis_Phase waveforms phase by phase.
- Captures the chain's dual-rail result and checks rail validity.
- Sits between the user-project logic and the analog EESPFAL array, in the vdda1/GND_GPIO domain.

---
 rtl/eespfal_pkg.sv | 34 +++
 rtl/eespfal_phase_timer.sv | 34 +++
 rtl/eespfal_phase_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/eespfal_pkg.sv
// Shared definitions for the EESPFAL phase sequencer.
//   state_e         : sequencer states
//   cnt_w()         : bit width of a 0..n-1 counter (at least 1)
//   dual_rail_valid : 1 when the low w bits of (s, s_bar) are complementary
package eespfal_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DISCH = 3'd1,
    EVAL  = 3'd2,
    CAPT  = 3'd3,
    RECOV = 3'd4
  } state_e;

  // Widest dual-rail bus dual_rail_valid can check.
  localparam int unsigned DR_MAX_W = 64;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A rail pair is invalid when both rails carry the same level (null or short).
  function automatic logic dual_rail_valid(input logic [DR_MAX_W-1:0] s,
                                           input logic [DR_MAX_W-1:0] s_bar,
                                           input int unsigned          w);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DR_MAX_W; i++) begin
      if ((i < w) && (s[i] == s_bar[i])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/eespfal_phase_timer.sv
// Phase timer: counts 0..PHASE_CYCLES-1 while enabled and wraps to 0.
// It therefore rests at 0 whenever it is disabled after a full phase.
//   CLK, RST_N : clock, async active-low reset
//   en_i       : count enable
//   tc_o       : high in the last cycle of a phase (while enabled)
module eespfal_phase_timer
  import eespfal_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned PC_W         = cnt_w(PHASE_CYCLES)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PHASE_CYCLES - 1);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en_i) pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PC_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign tc_o = en_i && (pc_q == PC_LAST);

endmodule

// File: rtl/eespfal_phase_seq.sv
// EESPFAL phase sequencer: drives a BIT_SIZE-wide, STAGES-deep chain of
// dual-rail switch cells through discharge, staged evaluation, capture and
// recovery, then captures and validity-checks the dual-rail result.
//   CLK, RST_N        : clock, async active-low reset
//   start             : request, accepted only when idle
//   x_in, k_in        : single-rail operand and per-stage keys
//   x/x_bar, k/k_bar  : dual-rail operand and keys (null = all 0 when idle)
//   pclk, Dis         : per-bit power-clock and discharge enables
//   Dis_Phase         : global discharge phase
//   s_in, s_bar_in    : dual-rail result from the last stage
//   result, busy, done, err : status and captured result
//   err_cnt           : saturating invalid-capture count, present only when
//                       EESPFAL_ERRCNT_EN is defined
// All outputs come straight from flops; their next values are decoded from
// the next state so they line up with the state register.
module eespfal_phase_seq
  import eespfal_pkg::*;
#(
  parameter int unsigned BIT_SIZE     = 4,
  parameter int unsigned STAGES       = 2,
  parameter int unsigned PHASE_CYCLES = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start,
  input  logic [BIT_SIZE-1:0]          x_in,
  input  logic [STAGES*BIT_SIZE-1:0]   k_in,
  output logic [BIT_SIZE-1:0]          x,
  output logic [BIT_SIZE-1:0]          x_bar,
  output logic [STAGES*BIT_SIZE-1:0]   k,
  output logic [STAGES*BIT_SIZE-1:0]   k_bar,
  output logic [STAGES*BIT_SIZE-1:0]   pclk,
  output logic [STAGES*BIT_SIZE-1:0]   Dis,
  output logic                         Dis_Phase,
  input  logic [BIT_SIZE-1:0]          s_in,
  input  logic [BIT_SIZE-1:0]          s_bar_in,
  output logic [BIT_SIZE-1:0]          result,
  output logic                         busy,
  output logic                         done,
  output logic                         err
`ifdef EESPFAL_ERRCNT_EN
  ,
  output logic [7:0]                   err_cnt
`endif
);

  localparam int unsigned    SC_W    = cnt_w(STAGES);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STAGES - 1);
  localparam int unsigned    KW      = STAGES * BIT_SIZE;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [BIT_SIZE-1:0] xl_q, xl_d;
  logic [KW-1:0]     kl_q, kl_d;

  logic [BIT_SIZE-1:0] x_q, x_d, x_bar_q, x_bar_d, result_q, result_d;
  logic [KW-1:0]     k_q, k_d, k_bar_q, k_bar_d, pclk_q, pclk_d, dis_q, dis_d;
  logic              dis_ph_q, dis_ph_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic tc, timer_en, err_det, rails_on;

  assign timer_en = (state_q == DISCH) || (state_q == EVAL) || (state_q == RECOV);

  eespfal_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en_i  (timer_en),
    .tc_o  (tc)
  );

  assign err_det = !dual_rail_valid(DR_MAX_W'(s_in), DR_MAX_W'(s_bar_in), BIT_SIZE);

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    xl_d    = xl_q;
    kl_d    = kl_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = DISCH;
        xl_d    = x_in;
        kl_d    = k_in;
      end
      DISCH: if (tc) begin
        state_d = EVAL;
        sc_d    = '0;
      end
      EVAL: if (tc) begin
        if (sc_q == SC_LAST) state_d = CAPT;
        else                 sc_d    = sc_q + SC_W'(1);
      end
      CAPT:  state_d = RECOV;
      RECOV: if (tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rails_on = (state_d != IDLE);
    x_d      = rails_on ? xl_d  : '0;
    x_bar_d  = rails_on ? ~xl_d : '0;
    k_d      = rails_on ? kl_d  : '0;
    k_bar_d  = rails_on ? ~kl_d : '0;

    pclk_d   = '0;
    dis_d    = '1;
    dis_ph_d = 1'b1;
    if (state_d == EVAL) begin
      dis_d    = '0;
      dis_ph_d = 1'b0;
      // Stage j stays powered during its own phase and the next one so the
      // following stage can evaluate from a held input.
      for (int unsigned j = 0; j < STAGES; j++) begin
        if ((32'(sc_d) == j) || (32'(sc_d) == j + 1))
          pclk_d[j*BIT_SIZE +: BIT_SIZE] = '1;
      end
    end else if (state_d == CAPT) begin
      dis_d    = '0;
      dis_ph_d = 1'b0;
      pclk_d[(STAGES-1)*BIT_SIZE +: BIT_SIZE] = '1;
    end

    busy_d   = (state_d != IDLE);
    done_d   = (state_q == RECOV) && (state_d == IDLE);

    result_d = result_q;
    err_d    = err_q;
    if ((state_q == IDLE) && start) err_d = 1'b0;
    if (state_q == CAPT) begin
      result_d = s_in;
      err_d    = err_det;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sc_q     <= '0;
      xl_q     <= '0;
      kl_q     <= '0;
      x_q      <= '0;
      x_bar_q  <= '0;
      k_q      <= '0;
      k_bar_q  <= '0;
      pclk_q   <= '0;
      dis_q    <= '1;
      dis_ph_q <= 1'b1;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      xl_q     <= xl_d;
      kl_q     <= kl_d;
      x_q      <= x_d;
      x_bar_q  <= x_bar_d;
      k_q      <= k_d;
      k_bar_q  <= k_bar_d;
      pclk_q   <= pclk_d;
      dis_q    <= dis_d;
      dis_ph_q <= dis_ph_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign x         = x_q;
  assign x_bar     = x_bar_q;
  assign k         = k_q;
  assign k_bar     = k_bar_q;
  assign pclk      = pclk_q;
  assign Dis       = dis_q;
  assign Dis_Phase = dis_ph_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef EESPFAL_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == CAPT) && err_det && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
